// File: rtl/time_pkg.sv
// Shared types and default widths for the time_base fine/coarse tick generator.
package time_pkg;

    localparam int DIV_W_DEFAULT = 16;
    localparam int SUB_W_DEFAULT = 10;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } tb_state_t;

    // A divisor of zero has no meaningful period, so either zero field poisons the config.
    function automatic logic cfg_invalid(input logic div_is_zero, input logic sub_is_zero);
        return div_is_zero || sub_is_zero;
    endfunction

endpackage

// File: rtl/time_base_if.sv
// Control and tick bundle between a time_base and whoever configures and consumes it.
interface time_base_if #(
    parameter int DIV_W = time_pkg::DIV_W_DEFAULT,
    parameter int SUB_W = time_pkg::SUB_W_DEFAULT
);
    // No valid/ready pairing: load_i and sync_i are strobes sampled on every rising
    // edge and acted on only when the block's state allows; run_i is a level.
    logic [DIV_W-1:0] div_i;
    logic [SUB_W-1:0] sub_div_i;
    logic             load_i;
    logic             run_i;
    logic             sync_i;
    logic             tick_fine_o;
    logic             tick_coarse_o;
    logic             running_o;
    logic             cfg_err_o;

    modport master (
        output div_i, sub_div_i, load_i, run_i, sync_i,
        input  tick_fine_o, tick_coarse_o, running_o, cfg_err_o
    );

    modport slave (
        input  div_i, sub_div_i, load_i, run_i, sync_i,
        output tick_fine_o, tick_coarse_o, running_o, cfg_err_o
    );

endinterface

// File: rtl/mod_counter.sv
// Modulo counter: counts 0..mod-1 while enabled, wraps, and flags the terminal value.
module mod_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic [W-1:0] mod_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Compare against mod-1 so a modulus of all-ones never needs a W+1 bit count.
    assign tc_o = (cnt_q == (mod_i - W'(1)));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tc_o ? '0 : (cnt_q + W'(1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/time_base.sv
// Two-level tick generator: a fine tick every div clocks, a coarse tick every sub_div fine ticks.
module time_base
    import time_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEFAULT,
    parameter int SUB_W = SUB_W_DEFAULT
) (
    input  logic      clk,
    input  logic      rst_n,
    time_base_if.slave bus,
    output tb_state_t state_o
);

    tb_state_t        state_q;
    tb_state_t        state_d;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic [SUB_W-1:0] sub_q;
    logic [SUB_W-1:0] sub_d;
    logic             cfg_err_q;
    logic             cfg_err_d;
    logic             tick_fine_q;
    logic             tick_fine_d;
    logic             tick_coarse_q;
    logic             tick_coarse_d;

    logic             stay_run;
    logic             cnt_clr;
    logic             fine_tc;
    logic             coarse_tc;

    // Counters only move on edges that keep us in RUN; leaving RUN or a sync zeroes them.
    assign stay_run = (state_q == RUN) && bus.run_i;
    assign cnt_clr  = !stay_run || bus.sync_i;

    mod_counter #(.W(DIV_W)) u_fine (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (stay_run),
        .clr_i (cnt_clr),
        .mod_i (div_q),
        .tc_o  (fine_tc)
    );

    mod_counter #(.W(SUB_W)) u_coarse (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (stay_run && fine_tc),
        .clr_i (cnt_clr),
        .mod_i (sub_q),
        .tc_o  (coarse_tc)
    );

    always_comb begin
        state_d       = state_q;
        div_d         = div_q;
        sub_d         = sub_q;
        cfg_err_d     = cfg_err_q;
        tick_fine_d   = 1'b0;
        tick_coarse_d = 1'b0;
        case (state_q)
            IDLE: begin
                // A load wins over run_i so RUN entry sees the freshly loaded error status.
                if (bus.load_i) begin
                    div_d     = bus.div_i;
                    sub_d     = bus.sub_div_i;
                    cfg_err_d = cfg_invalid(bus.div_i == '0, bus.sub_div_i == '0);
                end else if (bus.run_i && !cfg_err_q) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!bus.run_i) begin
                    state_d = IDLE;
                end else if (!bus.sync_i) begin
                    tick_fine_d   = fine_tc;
                    tick_coarse_d = fine_tc && coarse_tc;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            div_q         <= '0;
            sub_q         <= '0;
            cfg_err_q     <= 1'b1;
            tick_fine_q   <= 1'b0;
            tick_coarse_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            sub_q         <= sub_d;
            cfg_err_q     <= cfg_err_d;
            tick_fine_q   <= tick_fine_d;
            tick_coarse_q <= tick_coarse_d;
        end
    end

    assign bus.tick_fine_o   = tick_fine_q;
    assign bus.tick_coarse_o = tick_coarse_q;
    assign bus.running_o     = (state_q == RUN);
    assign bus.cfg_err_o     = cfg_err_q;
    assign state_o           = state_q;

endmodule

// File: tb/tb_time_base.sv
// Bench for time_base: per-cycle comparison against a cycle-age model plus directed scenarios.
module tb_time_base;
    import time_pkg::*;

    localparam int DW = 16;
    localparam int SW = 10;

    logic      clk   = 1'b0;
    logic      rst_n = 1'b0;
    tb_state_t state_o;

    time_base_if #(.DIV_W(DW), .SUB_W(SW)) bus ();

    time_base #(.DIV_W(DW), .SUB_W(SW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .state_o (state_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: RUN age counts edges since entry or sync; a fine tick falls on every
    // multiple of div, a coarse tick on every sub-th fine tick.
    bit m_run = 1'b0;
    int m_div = 0;
    int m_sub = 0;
    bit m_err = 1'b1;
    int m_age = 0;
    bit e_tf  = 1'b0;
    bit e_tc  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 1'b0;
        m_div = 0;
        m_sub = 0;
        m_err = 1'b1;
        m_age = 0;
        e_tf  = 1'b0;
        e_tc  = 1'b0;
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
            return;
        end
        e_tf = 1'b0;
        e_tc = 1'b0;
        if (!m_run) begin
            if (bus.load_i) begin
                m_div = int'(bus.div_i);
                m_sub = int'(bus.sub_div_i);
                m_err = (m_div == 0) || (m_sub == 0);
            end else if (bus.run_i && !m_err) begin
                m_run = 1'b1;
                m_age = 0;
            end
        end else if (!bus.run_i) begin
            m_run = 1'b0;
        end else if (bus.sync_i) begin
            m_age = 0;
        end else begin
            m_age++;
            e_tf = (m_age % m_div) == 0;
            e_tc = e_tf && (((m_age / m_div) % m_sub) == 0);
        end
    endtask

    always @(negedge clk) begin
        chk("tick_fine", bus.tick_fine_o, e_tf);
        chk("tick_coarse", bus.tick_coarse_o, e_tc);
        chk("running", bus.running_o, m_run);
        chk("cfg_err", bus.cfg_err_o, m_err);
        chk("state", state_o, m_run);
    end

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #2;
    endtask

    task automatic do_load(input int d, input int s);
        bus.div_i     = d[DW-1:0];
        bus.sub_div_i = s[SW-1:0];
        bus.load_i    = 1'b1;
        cyc();
        bus.load_i = 1'b0;
    endtask

    initial begin
        bus.div_i     = '0;
        bus.sub_div_i = '0;
        bus.load_i    = 1'b0;
        bus.run_i     = 1'b0;
        bus.sync_i    = 1'b0;
        repeat (3) cyc();
        rst_n = 1'b1;
        chk("rst_cfg_err", bus.cfg_err_o, 1);
        chk("rst_running", bus.running_o, 0);
        chk("rst_tick_fine", bus.tick_fine_o, 0);
        bus.run_i = 1'b1;
        repeat (2) cyc();
        chk("run_without_load", bus.running_o, 0);
        bus.run_i = 1'b0;
        cyc();

        // div=4 sub=3, load and run together
        bus.div_i     = 16'd4;
        bus.sub_div_i = 10'd3;
        bus.load_i    = 1'b1;
        bus.run_i     = 1'b1;
        cyc();
        bus.load_i = 1'b0;
        chk("a_load_first", bus.running_o, 0);
        cyc();
        chk("a_entry", bus.running_o, 1);
        for (int c = 1; c <= 12; c++) begin
            cyc();
            chk("a_tick_fine", bus.tick_fine_o, (c % 4) == 0);
            chk("a_tick_coarse", bus.tick_coarse_o, c == 12);
        end
        bus.run_i = 1'b0;
        cyc();
        chk("a_stop", bus.tick_fine_o, 0);

        // div=1 sub=1: both ticks every cycle after entry
        do_load(1, 1);
        bus.run_i = 1'b1;
        cyc();
        chk("b_entry_no_tick", bus.tick_fine_o, 0);
        for (int c = 1; c <= 5; c++) begin
            cyc();
            chk("b_tick_fine", bus.tick_fine_o, 1);
            chk("b_tick_coarse", bus.tick_coarse_o, 1);
        end
        bus.run_i = 1'b0;
        cyc();
        chk("b_stop_fine", bus.tick_fine_o, 0);
        chk("b_stop_coarse", bus.tick_coarse_o, 0);

        // zero divisor blocks RUN until a good reload
        do_load(0, 3);
        chk("c_err_set", bus.cfg_err_o, 1);
        bus.run_i = 1'b1;
        repeat (3) cyc();
        chk("c_blocked", bus.running_o, 0);
        bus.div_i     = 16'd5;
        bus.sub_div_i = 10'd2;
        bus.load_i    = 1'b1;
        cyc();
        bus.load_i = 1'b0;
        chk("c_err_clear", bus.cfg_err_o, 0);
        cyc();
        chk("c_entry", bus.running_o, 1);
        bus.run_i = 1'b0;
        cyc();

        // sync on a terminal-count edge
        do_load(4, 3);
        bus.run_i = 1'b1;
        cyc();
        repeat (3) cyc();
        bus.sync_i = 1'b1;
        cyc();
        bus.sync_i = 1'b0;
        chk("d_sync_no_tick", bus.tick_fine_o, 0);
        for (int c = 1; c <= 4; c++) begin
            cyc();
            chk("d_after_sync", bus.tick_fine_o, c == 4);
        end
        bus.run_i = 1'b0;
        cyc();

        // load in RUN is ignored; reload in IDLE takes effect
        do_load(4, 3);
        bus.run_i = 1'b1;
        cyc();
        bus.div_i  = 16'd7;
        bus.load_i = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            cyc();
            chk("e_period_kept", bus.tick_fine_o, (c % 4) == 0);
        end
        bus.load_i = 1'b0;
        bus.run_i  = 1'b0;
        cyc();
        do_load(7, 3);
        bus.run_i = 1'b1;
        cyc();
        for (int c = 1; c <= 7; c++) begin
            cyc();
            chk("e_new_period", bus.tick_fine_o, c == 7);
        end

        // asynchronous reset while a tick is high
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("f_tick_fine", bus.tick_fine_o, 0);
        chk("f_tick_coarse", bus.tick_coarse_o, 0);
        chk("f_running", bus.running_o, 0);
        chk("f_cfg_err", bus.cfg_err_o, 1);
        repeat (2) cyc();
        rst_n = 1'b1;
        repeat (3) cyc();
        chk("f_needs_load", bus.running_o, 0);
        bus.run_i = 1'b0;
        cyc();

        // randomized traffic, checked every cycle by the compare process
        do_load(3, 2);
        for (int i = 0; i < 2000; i++) begin
            bus.run_i  = ($urandom_range(0, 9) != 0);
            bus.sync_i = ($urandom_range(0, 11) == 0);
            bus.load_i = ($urandom_range(0, 5) == 0);
            if (bus.load_i) begin
                bus.div_i     = 16'($urandom_range(0, 6));
                bus.sub_div_i = 10'($urandom_range(0, 4));
            end
            cyc();
        end
        bus.run_i  = 1'b0;
        bus.sync_i = 1'b0;
        bus.load_i = 1'b0;
        repeat (2) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/time_base.md
TIME_BASE -- requirements
Module: time_base

Interface
REQ-001 Parameter DIV_W, default 16: width of fine divisor.
REQ-002 Parameter SUB_W, default 10: width of coarse sub-divisor.
REQ-003 The block SHALL provide port clk, input, 1: single clock; all logic on rising edge.
REQ-004 The block SHALL provide port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 The block SHALL provide port div_i, input, DIV_W: fine period in clk cycles.
REQ-006 The block SHALL provide port sub_div_i, input, SUB_W: coarse period in fine ticks.
REQ-007 The block SHALL provide port load_i, input, 1: capture div_i/sub_div_i into config registers.
REQ-008 The block SHALL provide port run_i, input, 1: level; high = generate ticks.
REQ-009 The block SHALL provide port sync_i, input, 1: pulse; realign both counters to phase zero.
REQ-010 The block SHALL provide port tick_fine_o, output, 1: one-cycle pulse per fine period; drives downstream timer enable (en_i).
REQ-011 The block SHALL provide port tick_coarse_o, output, 1: one-cycle pulse per coarse period.
REQ-012 The block SHALL provide port running_o, output, 1: high while in RUN.
REQ-013 The block SHALL provide port cfg_err_o, output, 1: sticky; a zero divisor was loaded.

Function
REQ-014 The block SHALL implement FSM states IDLE and RUN; reset state IDLE.
REQ-015 IDLE->RUN SHALL occur when run_i=1 and cfg_err_o=0; otherwise the block SHALL stay in IDLE.
REQ-016 RUN->IDLE SHALL occur on the first edge with run_i=0; both counters clear on that edge.
REQ-017 load_i SHALL be honoured only in IDLE; in RUN it SHALL be ignored and the config SHALL be unchanged.
REQ-018 A load with div_i=0 or sub_div_i=0 SHALL set cfg_err_o; a later load with both nonzero SHALL clear it.
REQ-019 If load_i and run_i are both high in IDLE, the block SHALL load first; RUN entry SHALL use the error status from the new config, one cycle later.
REQ-020 The fine counter SHALL count 0..div-1 in RUN and wrap to 0.
REQ-021 tick_fine_o SHALL be registered: first pulse exactly div cycles after the RUN entry edge, then every div cycles.
REQ-022 For div=1, tick_fine_o SHALL be high every RUN cycle after entry.
REQ-023 The coarse counter SHALL advance only on a fine tick, count 0..sub_div-1 and wrap.
REQ-024 tick_coarse_o SHALL pulse coincident with the fine tick that completes sub_div fine ticks.
REQ-025 sync_i in RUN SHALL clear both counters on the next edge; no tick SHALL be issued that cycle; the next fine tick SHALL follow div cycles after the sync edge.
REQ-026 sync_i SHALL take priority over a coincident terminal count.
REQ-027 sync_i SHALL be ignored in IDLE.
REQ-028 Both tick outputs SHALL be 0 whenever the state is IDLE.
REQ-029 Counter arithmetic SHALL be unsigned at DIV_W/SUB_W width; compares SHALL be against div-1 and sub_div-1 with no overflow past the maximum value.

Reset
REQ-030 On rst_n=0 the block SHALL asynchronously force IDLE, counters 0, config registers 0, tick_fine_o=0, tick_coarse_o=0, running_o=0, cfg_err_o=1 (zero config is invalid).
REQ-031 Reset asserted mid-RUN SHALL drop all ticks immediately; after release the block SHALL require load_i before RUN.

Structure
REQ-032 Package time_pkg SHALL hold the tb_state_t enum (IDLE, RUN) and the default DIV_W/SUB_W constants.
REQ-033 The block SHALL contain one sub-module, mod_counter (parameterised width, enable, clear, modulus, terminal-count output), instantiated twice: fine and coarse.

Verification
REQ-034 Scenario: load div=4, sub=3, run=1 -> tick_fine_o at RUN cycles 4, 8, 12, ...; tick_coarse_o with the fine tick at cycle 12.
REQ-035 Scenario: div=1, sub=1 -> both ticks high every RUN cycle after entry; run_i=0 -> both ticks 0 next cycle.
REQ-036 Scenario: load div=0 -> cfg_err_o=1; run_i=1 keeps IDLE; reload div=5, sub=2 -> cfg_err_o=0, RUN entered.
REQ-037 Scenario: div=4, sync_i on the edge of a terminal count -> no tick that cycle; next tick 4 cycles after the sync edge.
REQ-038 Scenario: load_i in RUN with div=7 -> period stays 4; after run_i=0 and a reload, period = 7.
REQ-039 Scenario: rst_n low mid-RUN -> all outputs 0 immediately except cfg_err_o=1; run_i=1 without a load stays IDLE.
